// File: rtl/conv_pkg.sv
// Shared sizing helpers and reset defaults for the binary-weight conv1 stage
// and the window buffer that feeds it.
package conv_pkg;

   localparam logic DEF_WEIGHT_BIT = 1'b1;
   localparam int   DEF_THRESH     = 0;

   function automatic int win_size(input int k);
      return k * k;
   endfunction

   // One sign bit plus enough headroom for WIN full-scale pixels.
   function automatic int sum_w(input int pix_w, input int k);
      return pix_w + $clog2(k * k) + 1;
   endfunction

   function automatic int pix_lo(input int idx, input int pix_w);
      return idx * pix_w;
   endfunction

endpackage

// File: rtl/bnn_dot.sv
// Signed +/-1 weighted sum of one window of unsigned pixels.
module bnn_dot
   import conv_pkg::*;
#(
   parameter int PIX_W = 8,
   parameter int WIN   = 9,
   parameter int SUM_W = PIX_W + $clog2(WIN) + 1
) (
   input  logic [WIN*PIX_W-1:0]    pix,
   input  logic [WIN-1:0]          w,
   output logic signed [SUM_W-1:0] s
);

   logic signed [SUM_W-1:0] p_ext;

   always_comb begin
      s     = '0;
      p_ext = '0;
      for (int i = 0; i < WIN; i++) begin
         p_ext = SUM_W'(pix[pix_lo(i, PIX_W) +: PIX_W]);
         s     = w[i] ? s + p_ext : s - p_ext;
      end
   end

endmodule

// File: rtl/conv1_bnn_pipe.sv
// Binary-weight first conv layer: one K x K window in, N_CH thresholded bits out,
// two register stages with valid/ready on both sides and run-time weights.
module conv1_bnn_pipe
   import conv_pkg::*;
#(
   parameter int PIX_W = 8,
   parameter int K     = 3,
   parameter int N_CH  = 8,
   parameter int SUM_W = sum_w(PIX_W, K)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cfg_we,
   input  logic [$clog2(N_CH)-1:0]   cfg_ch,
   input  logic [K*K-1:0]            cfg_weight,
   input  logic signed [SUM_W-1:0]   cfg_thresh,
   input  logic                      win_valid,
   output logic                      win_ready,
   input  logic [K*K*PIX_W-1:0]      win_pix,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [N_CH-1:0]           out_bits
);

   // Handshake: a transfer occurs on a cycle with valid && ready; ready never
   // depends on the local valid, and out_bits holds while out_valid && !out_ready.
   localparam int WIN  = win_size(K);
   localparam int CH_W = $clog2(N_CH);
   localparam int D_W  = SUM_W + 1;

   logic [WIN-1:0]          w_q  [N_CH];
   logic signed [SUM_W-1:0] t_q  [N_CH];
   logic signed [SUM_W-1:0] sum  [N_CH];
   logic signed [D_W-1:0]   diff [N_CH];
   logic signed [D_W-1:0]   d1_q [N_CH];
   logic                    s1_valid;
   logic                    s2_valid;
   logic                    s1_adv;
   logic                    s2_adv;
   logic                    accept;
   logic [N_CH-1:0]         bits_next;
   logic [N_CH-1:0]         bits_q;

   // Matching each slot against cfg_ch drops out-of-range channels for free.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < N_CH; c++) begin
            w_q[c] <= {WIN{DEF_WEIGHT_BIT}};
            t_q[c] <= SUM_W'(DEF_THRESH);
         end
      end else if (cfg_we) begin
         for (int c = 0; c < N_CH; c++) begin
            if (cfg_ch == CH_W'(c)) begin
               w_q[c] <= cfg_weight;
               t_q[c] <= cfg_thresh;
            end
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      bnn_dot #(
         .PIX_W (PIX_W),
         .WIN   (WIN),
         .SUM_W (SUM_W)
      ) u_dot (
         .pix (win_pix),
         .w   (w_q[g]),
         .s   (sum[g])
      );
      assign diff[g]      = $signed({sum[g][SUM_W-1], sum[g]}) - $signed({t_q[g][SUM_W-1], t_q[g]});
      assign bits_next[g] = !d1_q[g][D_W-1] && (d1_q[g] != '0);
   end

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign win_ready = s1_adv;
   assign accept    = win_valid && s1_adv;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         bits_q   <= '0;
         for (int c = 0; c < N_CH; c++) begin
            d1_q[c] <= '0;
         end
      end else begin
         if (s1_adv) begin
            s1_valid <= accept;
         end
         if (accept) begin
            for (int c = 0; c < N_CH; c++) begin
               d1_q[c] <= diff[c];
            end
         end
         // Empty slots load zero so out_bits reads 0 whenever out_valid is low.
         if (s2_adv) begin
            s2_valid <= s1_valid;
            bits_q   <= s1_valid ? bits_next : '0;
         end
      end
   end

   assign out_valid = s2_valid;
   assign out_bits  = bits_q;

endmodule

// File: tb/tb_conv1_bnn_pipe.sv
// Directed bench for conv1_bnn_pipe: vector table, backpressure stream,
// config/acceptance collision, mid-stream reset, out-of-range channel writes.
module tb_conv1_bnn_pipe;

   localparam int PIX_W = 8;
   localparam int WIN   = 9;
   localparam int N_CH  = 8;
   localparam int SUM_W = 13;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    cfg_we;
   logic [2:0]              cfg_ch;
   logic [WIN-1:0]          cfg_weight;
   logic signed [SUM_W-1:0] cfg_thresh;
   logic                    win_valid;
   logic                    win_ready;
   logic [WIN*PIX_W-1:0]    win_pix;
   logic                    out_valid;
   logic                    out_ready;
   logic [N_CH-1:0]         out_bits;

   logic                    cfg_we2;
   logic [2:0]              cfg_ch2;
   logic                    win_valid2;
   logic                    win_ready2;
   logic                    out_valid2;
   logic                    out_ready2;
   logic [5:0]              out_bits2;

   int errors = 0;
   int checks = 0;

   logic [WIN-1:0]          m_w [N_CH];
   logic signed [SUM_W-1:0] m_t [N_CH];

   typedef struct {
      string                   name;
      logic                    cfg_en;
      logic [2:0]              ch;
      logic [WIN-1:0]          w;
      logic signed [SUM_W-1:0] t;
      logic [WIN*PIX_W-1:0]    pix;
      logic [N_CH-1:0]         exp;
   } vec_t;

   vec_t vecs[$];

   conv1_bnn_pipe #(.PIX_W(8), .K(3), .N_CH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_weight (cfg_weight),
      .cfg_thresh (cfg_thresh),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_pix    (win_pix),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_bits   (out_bits)
   );

   // Six channels leave codes 6 and 7 free to exercise ignored writes.
   conv1_bnn_pipe #(.PIX_W(8), .K(3), .N_CH(6)) dut6 (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_we     (cfg_we2),
      .cfg_ch     (cfg_ch2),
      .cfg_weight (cfg_weight),
      .cfg_thresh (cfg_thresh),
      .win_valid  (win_valid2),
      .win_ready  (win_ready2),
      .win_pix    (win_pix),
      .out_valid  (out_valid2),
      .out_ready  (out_ready2),
      .out_bits   (out_bits2)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [WIN*PIX_W-1:0] uni(input logic [7:0] v);
      logic [WIN*PIX_W-1:0] r;
      for (int i = 0; i < WIN; i++) r[i*PIX_W +: PIX_W] = v;
      return r;
   endfunction

   function automatic logic [WIN*PIX_W-1:0] ramp10();
      logic [WIN*PIX_W-1:0] r;
      for (int i = 0; i < WIN; i++) r[i*PIX_W +: PIX_W] = 8'(i * 10);
      return r;
   endfunction

   function automatic logic [WIN*PIX_W-1:0] bp_pix(input int k);
      logic [WIN*PIX_W-1:0] r;
      for (int i = 0; i < WIN; i++) r[i*PIX_W +: PIX_W] = 8'((k * 37 + i * 23) & 255);
      return r;
   endfunction

   function automatic logic [N_CH-1:0] model(input logic [WIN*PIX_W-1:0] pix);
      logic [N_CH-1:0] r;
      int s;
      for (int c = 0; c < N_CH; c++) begin
         s = 0;
         for (int i = 0; i < WIN; i++) begin
            s += m_w[c][i] ? int'(pix[i*PIX_W +: PIX_W]) : -int'(pix[i*PIX_W +: PIX_W]);
         end
         r[c] = (s - int'(m_t[c])) > 0;
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < N_CH; c++) begin
         m_w[c] = '1;
         m_t[c] = '0;
      end
   endtask

   task automatic add_vec(input string name, input logic cfg_en, input logic [2:0] ch,
                          input logic [WIN-1:0] w, input logic signed [SUM_W-1:0] t,
                          input logic [WIN*PIX_W-1:0] pix, input logic [N_CH-1:0] exp);
      vec_t v;
      v.name = name; v.cfg_en = cfg_en; v.ch = ch; v.w = w; v.t = t; v.pix = pix; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic cfg_write(input logic [2:0] ch, input logic [WIN-1:0] w,
                            input logic signed [SUM_W-1:0] t);
      @(negedge clk);
      cfg_we = 1'b1; cfg_ch = ch; cfg_weight = w; cfg_thresh = t;
      @(negedge clk);
      cfg_we = 1'b0;
      m_w[ch] = w;
      m_t[ch] = t;
   endtask

   // Present one window, then expect the result two cycles after acceptance.
   task automatic run_window(input string name, input logic [WIN*PIX_W-1:0] pix,
                             input logic [N_CH-1:0] exp);
      int n;
      @(negedge clk);
      out_ready = 1'b1; win_valid = 1'b1; win_pix = pix;
      #1;
      n = 0;
      while (!win_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({name, "_accept"}, 32'(win_ready), 32'(1'b1));
      @(negedge clk);
      win_valid = 1'b0;
      #1;
      check({name, "_lat1_valid"}, 32'(out_valid), 32'(1'b0));
      @(negedge clk);
      #1;
      check({name, "_valid"}, 32'(out_valid), 32'(1'b1));
      check({name, "_bits"}, 32'(out_bits), 32'(exp));
   endtask

   task automatic backpressure();
      int sent = 0, recv = 0, acc_early = 0, ready_in_stall = 0, zero_viol = 0, extra = 0;
      logic [N_CH-1:0] exp_q[$];
      logic [N_CH-1:0] e;
      for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 2 && cyc <= 7);
         if (sent < 6) begin
            win_valid = 1'b1;
            win_pix   = bp_pix(sent + 1);
         end else begin
            win_valid = 1'b0;
         end
         #1;
         if (cyc >= 2 && cyc <= 7 && win_ready) ready_in_stall++;
         if (cyc == 8) check("bp_ready_rise", 32'(win_ready), 32'(1'b1));
         if (!out_valid && out_bits != '0) zero_viol++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               extra++;
            end else begin
               e = exp_q.pop_front();
               check($sformatf("bp_out%0d", recv), 32'(out_bits), 32'(e));
            end
            recv++;
         end
         if (win_valid && win_ready) begin
            exp_q.push_back(model(win_pix));
            sent++;
            if (cyc < 2) acc_early++;
         end
      end
      @(negedge clk);
      win_valid = 1'b0;
      out_ready = 1'b1;
      check("bp_accept_before_stall", 32'(acc_early), 32'd2);
      check("bp_ready_during_stall", 32'(ready_in_stall), 32'd0);
      check("bp_sent", 32'(sent), 32'd6);
      check("bp_received", 32'(recv), 32'd6);
      check("bp_extra_outputs", 32'(extra), 32'd0);
      check("bp_leftover", 32'(exp_q.size()), 32'd0);
      check("bp_bits_zero_when_idle", 32'(zero_viol), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_weight = '0; cfg_thresh = '0;
      win_valid = 1'b0; win_pix = '0; out_ready = 1'b1;
      cfg_we2 = 1'b0; cfg_ch2 = '0; win_valid2 = 1'b0; out_ready2 = 1'b1;
      model_reset();

      // Sequential table: each row may write one channel, then sends one window.
      add_vec("dflt_10",     1'b0, 3'd0, 9'h000,       13'sd0,    uni(8'd10),  8'hFF);
      add_vec("dflt_0",      1'b0, 3'd0, 9'h000,       13'sd0,    uni(8'd0),   8'h00);
      add_vec("signed_w",    1'b1, 3'd0, 9'b011000000, 13'sd0,    uni(8'd255), 8'hFE);
      add_vec("thr_eq",      1'b1, 3'd3, 9'h1FF,       13'sd2295, uni(8'd255), 8'hF6);
      add_vec("thr_below",   1'b1, 3'd3, 9'h1FF,       13'sd2294, uni(8'd255), 8'hFE);
      add_vec("thr_neg",     1'b1, 3'd3, 9'h1FF,      -13'sd1,    uni(8'd0),   8'h08);
      add_vec("all_minus",   1'b1, 3'd5, 9'h000,      -13'sd80,   uni(8'd10),  8'hDE);
      add_vec("ramp",        1'b1, 3'd1, 9'h100,       13'sd0,    ramp10(),    8'hDC);

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'(1'b0));
      check("rst_out_bits", 32'(out_bits), 32'(8'h00));
      check("rst_win_ready", 32'(win_ready), 32'(1'b1));
      check("rst6_out_valid", 32'(out_valid2), 32'(1'b0));
      check("rst6_win_ready", 32'(win_ready2), 32'(1'b1));

      foreach (vecs[i]) begin
         if (vecs[i].cfg_en) cfg_write(vecs[i].ch, vecs[i].w, vecs[i].t);
         run_window(vecs[i].name, vecs[i].pix, vecs[i].exp);
      end

      backpressure();

      // Window A shares its acceptance cycle with a ch0 rewrite; B follows.
      @(negedge clk);
      out_ready = 1'b1; win_valid = 1'b1; win_pix = uni(8'd10);
      cfg_we = 1'b1; cfg_ch = 3'd0; cfg_weight = 9'h1FF; cfg_thresh = 13'sd0;
      #1;
      check("coll_ready_a", 32'(win_ready), 32'(1'b1));
      @(negedge clk);
      cfg_we = 1'b0;
      #1;
      check("coll_ready_b", 32'(win_ready), 32'(1'b1));
      @(negedge clk);
      win_valid = 1'b0;
      #1;
      check("coll_a_valid", 32'(out_valid), 32'(1'b1));
      check("coll_a_old_cfg", 32'(out_bits), 32'(8'hDC));
      @(negedge clk);
      #1;
      check("coll_b_valid", 32'(out_valid), 32'(1'b1));
      check("coll_b_new_cfg", 32'(out_bits), 32'(8'hDD));
      m_w[0] = 9'h1FF;
      m_t[0] = '0;

      // Two windows parked under backpressure, then reset with a write in the same cycle.
      @(negedge clk);
      out_ready = 1'b0; win_valid = 1'b1; win_pix = uni(8'd10);
      @(negedge clk);
      @(negedge clk);
      win_valid = 1'b0;
      #1;
      check("mid_inflight_valid", 32'(out_valid), 32'(1'b1));
      check("mid_inflight_ready", 32'(win_ready), 32'(1'b0));
      rst_n = 1'b0;
      cfg_we = 1'b1; cfg_ch = 3'd4; cfg_weight = 9'h000; cfg_thresh = 13'sd100;
      @(negedge clk);
      rst_n = 1'b1; cfg_we = 1'b0; out_ready = 1'b1;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'(1'b0));
      check("mid_rst_out_bits", 32'(out_bits), 32'(8'h00));
      check("mid_rst_win_ready", 32'(win_ready), 32'(1'b1));
      model_reset();
      run_window("mid_rst_defaults", uni(8'd10), 8'hFF);

      // Codes 6 and 7 do not name a channel on the six-channel instance.
      @(negedge clk);
      cfg_we2 = 1'b1; cfg_ch2 = 3'd6; cfg_weight = 9'h000; cfg_thresh = 13'sd1000;
      @(negedge clk);
      cfg_ch2 = 3'd7;
      @(negedge clk);
      cfg_we2 = 1'b0; win_valid2 = 1'b1; win_pix = uni(8'd10);
      #1;
      check("oor_ready", 32'(win_ready2), 32'(1'b1));
      @(negedge clk);
      win_valid2 = 1'b0;
      @(negedge clk);
      #1;
      check("oor_valid", 32'(out_valid2), 32'(1'b1));
      check("oor_bits", 32'(out_bits2), 32'(6'h3F));
      @(negedge clk);
      cfg_we2 = 1'b1; cfg_ch2 = 3'd2; cfg_weight = 9'h000; cfg_thresh = 13'sd0;
      @(negedge clk);
      cfg_we2 = 1'b0; win_valid2 = 1'b1;
      @(negedge clk);
      win_valid2 = 1'b0;
      @(negedge clk);
      #1;
      check("inrange_valid", 32'(out_valid2), 32'(1'b1));
      check("inrange_bits", 32'(out_bits2), 32'(6'h3B));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
